// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: default payload width, reset/flush constants and
// the packed stage payloads that callers size pipe_skid_stage WIDTH from.
package pipe_pkg;

   localparam int unsigned PIPE_DATA_W = 16;

   localparam logic [PIPE_DATA_W-1:0] PIPE_RESET_VAL = '0;
   localparam logic [PIPE_DATA_W-1:0] PIPE_FLUSH_VAL = '0;

   typedef enum logic [1:0] {
      MODE_USER    = 2'd0,
      MODE_SUPER   = 2'd1,
      MODE_MACHINE = 2'd3
   } mode_e;

   // mode sits in the top bits so a KEEP_MASK over the MSBs tracks it through a flush
   typedef struct packed {
      mode_e                  mode;
      logic [4:0]             rd;
      logic [3:0]             alu_op;
      logic                   use_imm;
      logic [PIPE_DATA_W-1:0] imm;
   } id_ex_t;

   typedef struct packed {
      mode_e                  mode;
      logic [4:0]             rd;
      logic                   mem_we;
      logic                   mem_re;
      logic [PIPE_DATA_W-1:0] result;
   } ex_mem_t;

   localparam int unsigned ID_EX_W  = $bits(id_ex_t);
   localparam int unsigned EX_MEM_W = $bits(ex_mem_t);

endpackage

// File: rtl/pipe_skid_stage.sv
// Pipeline stage register with valid/ready handshake and a one-word skid entry,
// so in_ready comes straight from a flop and stalls never chain across stages.
module pipe_skid_stage
   import pipe_pkg::*;
#(
   parameter int unsigned      WIDTH     = PIPE_DATA_W,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   parameter logic [WIDTH-1:0] FLUSH_VAL = '0,
   parameter logic [WIDTH-1:0] KEEP_MASK = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       occupancy
);

   logic             r_out_valid;
   logic [WIDTH-1:0] r_out_data;
   logic             r_skid_valid;
   logic [WIDTH-1:0] r_skid_data;

   logic             w_acc;
   logic             w_drn;

   // Sideband bits under KEEP_MASK follow the input even though the word is killed
   function automatic logic [WIDTH-1:0] f_flush_word(input logic [WIDTH-1:0] d);
      return (FLUSH_VAL & ~KEEP_MASK) | (d & KEEP_MASK);
   endfunction

   assign w_acc = in_valid & ~r_skid_valid & ~flush;
   assign w_drn = r_out_valid & out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid  <= 1'b0;
         r_out_data   <= RESET_VAL;
         r_skid_valid <= 1'b0;
         r_skid_data  <= RESET_VAL;
      end else if (flush) begin
         r_out_valid  <= 1'b0;
         r_skid_valid <= 1'b0;
         r_out_data   <= f_flush_word(in_data);
      end else if (!r_out_valid) begin
         if (w_acc) begin
            r_out_valid <= 1'b1;
            r_out_data  <= in_data;
         end
      end else if (!r_skid_valid) begin
         if (w_acc && w_drn) begin
            r_out_data <= in_data;
         end else if (w_acc) begin
            r_skid_valid <= 1'b1;
            r_skid_data  <= in_data;
         end else if (w_drn) begin
            r_out_valid <= 1'b0;
         end
      end else if (w_drn) begin
         // Both entries full: in_ready is low, so only a drain can move data
         r_out_data   <= r_skid_data;
         r_skid_valid <= 1'b0;
      end
   end

   assign in_ready  = ~r_skid_valid;
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign occupancy = {1'b0, r_out_valid} + {1'b0, r_skid_valid};

   a_skid_implies_main: assert property (
      @(posedge clk) disable iff (!rst_n) !(r_skid_valid && !r_out_valid));

   a_stable_under_stall: assert property (
      @(posedge clk) disable iff (!rst_n)
      (r_out_valid && !out_ready && !flush) |=> $stable(r_out_data));

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: queue-based reference of a two-deep stage checked
// every cycle, plus directed streaming, back-pressure, flush, reset and random traffic.
module tb_pipe_skid_stage;

   localparam logic [15:0] RST_V  = 16'h5A5A;
   localparam logic [15:0] FLSH_V = 16'h0000;
   localparam logic [15:0] KEEP   = 16'hC000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] in_data = 16'h0000;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] out_data;
   logic [1:0]  occupancy;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   pipe_skid_stage #(
      .WIDTH    (16),
      .RESET_VAL(RST_V),
      .FLUSH_VAL(FLSH_V),
      .KEEP_MASK(KEEP)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data),
      .occupancy(occupancy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference: the stage is a FIFO of depth two whose in_ready reflects the
   // fill level before the edge; idle out_data is pinned only after reset/flush.
   logic [15:0] mq[$];
   logic [15:0] m_hold = RST_V;
   bit          m_hold_known = 1'b1;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mq.delete();
         m_hold       = RST_V;
         m_hold_known = 1'b1;
      end else if (flush) begin
         mq.delete();
         m_hold       = (FLSH_V & ~KEEP) | (in_data & KEEP);
         m_hold_known = 1'b1;
      end else begin
         int n;
         bit acc;
         bit drn;
         n   = mq.size();
         acc = in_valid && (n < 2);
         drn = (n > 0) && out_ready;
         if (drn) void'(mq.pop_front());
         if (acc) begin
            mq.push_back(in_data);
            m_hold_known = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("cmp_out_valid", 32'(out_valid), 32'(mq.size() > 0));
         check("cmp_in_ready", 32'(in_ready), 32'(mq.size() < 2));
         check("cmp_occupancy", 32'(occupancy), 32'(mq.size()));
         if (mq.size() > 0)
            check("cmp_out_data", 32'(out_data), 32'(mq[0]));
         else if (m_hold_known)
            check("cmp_out_data_idle", 32'(out_data), 32'(m_hold));
      end
   end

   initial begin
      // Reset
      step();
      step();
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_occupancy", 32'(occupancy), 32'd0);
      check("rst_out_data", 32'(out_data), 32'h5A5A);
      rst_n  = 1'b1;
      chk_en = 1'b1;

      // Streaming, out_ready held high
      out_ready = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         in_valid = 1'b1;
         in_data  = 16'(k);
         step();
         check("stream_data", 32'(out_data), 32'(k));
         check("stream_in_ready", 32'(in_ready), 32'd1);
         check("stream_occ", 32'(occupancy), 32'd1);
      end
      in_valid = 1'b0;
      step();
      check("stream_empty", 32'(occupancy), 32'd0);

      // Back-pressure
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 16'hAAAA;
      step();
      check("bp_occ1", 32'(occupancy), 32'd1);
      check("bp_rdy1", 32'(in_ready), 32'd1);
      in_data = 16'hBBBB;
      step();
      check("bp_occ2", 32'(occupancy), 32'd2);
      check("bp_rdy0", 32'(in_ready), 32'd0);
      check("bp_hold", 32'(out_data), 32'hAAAA);
      in_data = 16'hCCCC;
      step();
      step();
      check("bp_hold2", 32'(out_data), 32'hAAAA);
      check("bp_occ2b", 32'(occupancy), 32'd2);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      check("bp_second", 32'(out_data), 32'hBBBB);
      check("bp_rdy_back", 32'(in_ready), 32'd1);
      check("bp_occ_after", 32'(occupancy), 32'd1);
      step();
      check("bp_drained", 32'(occupancy), 32'd0);

      // Flush from FULL with sideband bits kept
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 16'h1111;
      step();
      in_data = 16'h2222;
      step();
      check("fl_full", 32'(occupancy), 32'd2);
      flush   = 1'b1;
      in_data = 16'h8123;
      step();
      check("fl_out_valid", 32'(out_valid), 32'd0);
      check("fl_occ", 32'(occupancy), 32'd0);
      check("fl_in_ready", 32'(in_ready), 32'd1);
      check("fl_out_data", 32'(out_data), 32'h8000);
      flush    = 1'b0;
      in_valid = 1'b0;
      step();
      check("fl_idle_data", 32'(out_data), 32'h8000);

      // Async reset mid-burst, between edges
      out_ready = 1'b1;
      in_valid  = 1'b1;
      for (int k = 0; k < 3; k++) begin
         in_data = 16'h0100 + 16'(k);
         step();
      end
      check("ar_busy", 32'(out_valid), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      check("ar_out_valid", 32'(out_valid), 32'd0);
      check("ar_occ", 32'(occupancy), 32'd0);
      check("ar_in_ready", 32'(in_ready), 32'd1);
      check("ar_out_data", 32'(out_data), 32'h5A5A);
      in_valid = 1'b0;
      step();
      step();
      rst_n    = 1'b1;
      in_valid = 1'b1;
      in_data  = 16'h0777;
      check("ar_pre_accept", 32'(out_valid), 32'd0);
      step();
      check("ar_first_valid", 32'(out_valid), 32'd1);
      check("ar_first_data", 32'(out_data), 32'h0777);
      in_valid = 1'b0;
      step();

      // Random traffic
      for (int i = 0; i < 10000; i++) begin
         in_valid  = 1'($urandom_range(0, 1));
         out_ready = 1'($urandom_range(0, 1));
         flush     = ($urandom_range(0, 63) == 0);
         in_data   = 16'($urandom);
         step();
      end
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      step();
      step();
      check("rnd_drained", 32'(occupancy), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
